j68_dec_issue: RTL and testbench
================================

J68_DEC_ISSUE -- requirements
Module: j68_dec_issue

Interface
REQ-001 SHALL have parameter DEC_W, default 36, the decode word width returned by the decode ROM.
REQ-002 SHALL have port clock, input, 1, the single clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, opcode offered by the prefetch stage.
REQ-005 SHALL have port in_ready, output, 1, opcode accepted this cycle when high with in_valid.
REQ-006 SHALL have port in_opcode, input, 16, 68000 instruction word.
REQ-007 SHALL have port flush, input, 1, discard the held opcode (branch/exception).
REQ-008 SHALL have port rom_addr, output, 8, address to the synchronous 1-cycle-latency decode ROM.
REQ-009 SHALL have port rom_q, input, DEC_W, ROM data for the address presented on the previous edge.
REQ-010 SHALL have port out_valid, output, 1, decode word available to the microsequencer.
REQ-011 SHALL have port out_ready, input, 1, microsequencer consumes the word this cycle.
REQ-012 SHALL have ports out_word (DEC_W), out_opcode (16), out_line_a (1) and out_line_f (1), all outputs: the decode word, held opcode, line-A flag and line-F flag.

Function
REQ-013 SHALL implement two states: IDLE (nothing held) and VALID (word held, out_valid=1).
REQ-014 SHALL define in_fire = in_valid & in_ready, and on in_fire SHALL load op_r <= in_opcode and enter VALID.
REQ-015 SHALL map opcode to address as addr = {op[15:12], op[8:6], op[5]}.
REQ-016 SHALL drive rom_addr = map(in_opcode) in an in_fire cycle, otherwise map(op_r), so the ROM address stays stable while VALID.
REQ-017 SHALL drive out_word = rom_q combinationally, giving out_valid exactly 1 cycle after in_fire.
REQ-018 SHALL drive out_opcode = op_r, out_line_a = (op_r[15:12]==4'hA) and out_line_f = (op_r[15:12]==4'hF).
REQ-019 SHALL, in VALID with out_ready=1 and no in_fire, return to IDLE on the next edge.
REQ-020 SHALL, in VALID with out_valid=1 and out_ready=0, hold out_word, out_opcode and the flags stable.
REQ-021 SHALL assert in_ready=1 in IDLE; in VALID, in_ready is set per REQ-027/028.
REQ-022 SHALL force in_ready=0 while flush=1, and on flush enter IDLE on the next edge (flush wins over any in_fire or out handshake).

Reset
REQ-023 SHALL on reset_n=0 at an edge enter IDLE and clear op_r to 16'h0000, giving out_valid=0.
REQ-024 SHALL hold in_ready=0 while reset_n=0.
REQ-025 SHALL discard a word held in VALID when reset is applied mid-operation; it is not replayed.

Configuration
REQ-026 SHALL support macro J68_DEC_PIPE_EN.
REQ-027 SHALL, without J68_DEC_PIPE_EN, drive in_ready=0 in VALID: at most one opcode every 2 cycles.
REQ-028 SHALL, with J68_DEC_PIPE_EN, drive in_ready=out_ready in VALID; simultaneous consume and in_fire stays in VALID with the new opcode, giving 1 opcode per cycle.

Structure
REQ-029 SHALL place DEC_W default, ADDR_W=8, the state enum, the address-map function and the line-A/F constants in shared package j68_pkg.
REQ-030 SHALL contain no sub-module; the decode ROM is instantiated by the parent.

Verification
REQ-031 SHALL verify: reset, then in_opcode=16'h4E71 with in_valid -> rom_addr=8'h43 that cycle, out_valid=1 next cycle, out_opcode=16'h4E71 and out_line_a=0.
REQ-032 SHALL verify: in_opcode=16'hA000 -> rom_addr=8'hA0 and out_line_a=1; in_opcode=16'hF200 -> rom_addr=8'hF0 and out_line_f=1.
REQ-033 SHALL verify: out_ready=0 for 5 cycles -> out_word, out_opcode and rom_addr stay constant, and in_ready=0.
REQ-034 SHALL verify: flush asserted together with in_valid in VALID -> in_ready=0 and out_valid=0 the next cycle.
REQ-035 SHALL verify: 8 back-to-back opcodes with out_ready=1 -> 16 cycles without J68_DEC_PIPE_EN and 8 cycles plus 1 latency cycle with it, in order and with no loss.
REQ-036 SHALL verify: reset_n=0 while VALID -> out_valid=0 next cycle and op_r=16'h0000.

Source files
------------

// File: rtl/j68_pkg.sv
// j68_pkg: shared decode-issue types, widths, opcode-to-ROM address map and line-A/F constants.
package j68_pkg;
   localparam int DEC_W_DEFAULT = 36;
   localparam int ADDR_W = 8;
   localparam logic [3:0] LINE_A = 4'hA;
   localparam logic [3:0] LINE_F = 4'hF;
   typedef enum logic {IDLE, VALID} state_t;
   function automatic logic [ADDR_W-1:0] dec_addr(input logic [15:0] op);
      return {op[15:12], op[8:6], op[5]};
   endfunction
endpackage

// File: rtl/j68_dec_issue.sv
// j68_dec_issue: holds one opcode, addresses the 1-cycle decode ROM and presents the word to the microsequencer.
// Define J68_DEC_PIPE_EN to accept a new opcode in the same cycle the held word is consumed.
module j68_dec_issue
   import j68_pkg::*;
#(
   parameter int DEC_W = DEC_W_DEFAULT
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [15:0]       in_opcode,
   input  logic              flush,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DEC_W-1:0]  rom_q,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DEC_W-1:0]  out_word,
   output logic [15:0]       out_opcode,
   output logic              out_line_a,
   output logic              out_line_f
);
   state_t state_q, state_d;
   logic [15:0] op_q, op_d;
   logic can_take, in_fire;
   always_comb begin
`ifdef J68_DEC_PIPE_EN
      can_take = (state_q == IDLE) | out_ready;
`else
      can_take = (state_q == IDLE);
`endif
      in_ready = reset_n & ~flush & can_take;
      in_fire = in_valid & in_ready;
      op_d = in_fire ? in_opcode : op_q;
      // flush outranks both handshakes; a fire while consuming keeps VALID with the new opcode
      state_d = flush ? IDLE : in_fire ? VALID : (state_q == VALID && out_ready) ? IDLE : state_q;
      rom_addr = dec_addr(op_d);
   end
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= IDLE;
         op_q <= 16'h0000;
      end else begin
         state_q <= state_d;
         op_q <= op_d;
      end
   end
   assign out_valid = (state_q == VALID);
   assign out_word = rom_q;
   assign out_opcode = op_q;
   assign out_line_a = (op_q[15:12] == LINE_A);
   assign out_line_f = (op_q[15:12] == LINE_F);
endmodule

// File: tb/tb_j68_dec_issue.sv
// tb_j68_dec_issue: directed vectors plus a cycle-by-cycle reference model of the decode issue stage.
module tb_j68_dec_issue;
   localparam int DW = 36;
`ifdef J68_DEC_PIPE_EN
   localparam bit PIPE = 1'b1;
`else
   localparam bit PIPE = 1'b0;
`endif
   logic clock = 0, reset_n = 0, in_valid = 0, flush = 0, out_ready = 1;
   logic in_ready, out_valid, out_line_a, out_line_f;
   logic [15:0] in_opcode = 16'h0000, out_opcode;
   logic [7:0] rom_addr;
   logic [DW-1:0] rom_q, out_word;
   int vecs = 0, errs = 0;
   bit chk_en = 0;
   logic m_valid = 0, m_fire;
   logic [15:0] m_op = 16'h0000;
   logic [15:0] ops [8] = '{16'h4E71, 16'hA00C, 16'h3028, 16'hF3E0, 16'h1234, 16'hD041, 16'h6700, 16'h20BF};

   j68_dec_issue #(.DEC_W(DW)) dut (
      .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_opcode(in_opcode), .flush(flush), .rom_addr(rom_addr), .rom_q(rom_q),
      .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
      .out_opcode(out_opcode), .out_line_a(out_line_a), .out_line_f(out_line_f)
   );

   always #5 clock = ~clock;

   function automatic logic [7:0] tb_map(input logic [15:0] op);
      return 8'(((op >> 5) & 16'h000F) | ((op >> 8) & 16'h00F0));
   endfunction

   function automatic logic [DW-1:0] rom_fn(input logic [7:0] a);
      return {a, ~a, a, ~a, 4'h5};
   endfunction

   always @(posedge clock) rom_q <= rom_fn(rom_addr);

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   assign m_fire = reset_n & ~flush & in_valid & (~m_valid | (PIPE & out_ready));

   always @(posedge clock) begin
      if (!reset_n) begin
         m_valid <= 0;
         m_op <= 16'h0000;
      end else if (flush) m_valid <= 0;
      else if (m_fire) begin
         m_valid <= 1;
         m_op <= in_opcode;
      end else if (m_valid && out_ready) m_valid <= 0;
   end

   always @(negedge clock) begin
      if (chk_en) begin
         chk("m_in_ready", in_ready, reset_n & ~flush & (~m_valid | (PIPE & out_ready)));
         chk("m_out_valid", out_valid, m_valid);
         chk("m_rom_addr", rom_addr, tb_map(m_fire ? in_opcode : m_op));
         if (m_valid) begin
            chk("m_out_opcode", out_opcode, m_op);
            chk("m_out_word", out_word, rom_fn(tb_map(m_op)));
            chk("m_line_a", out_line_a, m_op[15:12] == 4'd10);
            chk("m_line_f", out_line_f, m_op[15:12] == 4'd15);
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic issue(input logic [15:0] op, input logic [7:0] ea, input logic [DW-1:0] ew, input logic la, input logic lf);
      in_valid = 1;
      in_opcode = op;
      @(negedge clock);
      chk("issue_rom_addr", rom_addr, ea);
      step();
      in_valid = 0;
      @(negedge clock);
      chk("issue_out_valid", out_valid, 1);
      chk("issue_out_opcode", out_opcode, op);
      chk("issue_out_word", out_word, ew);
      chk("issue_line_a", out_line_a, la);
      chk("issue_line_f", out_line_f, lf);
      step();
   endtask

   task automatic stream();
      int idx = 0, cons = 0, n = 0;
      out_ready = 1;
      while (cons < 8 && n < 40) begin
         in_valid = (idx < 8);
         in_opcode = ops[idx < 8 ? idx : 7];
         @(negedge clock);
         if (out_valid && out_ready) begin
            chk("stream_order", out_opcode, ops[cons]);
            cons++;
         end
         if (in_valid && in_ready) idx++;
         n++;
         step();
      end
      in_valid = 0;
      chk("stream_count", cons, 8);
      chk("stream_cycles", n, PIPE ? 9 : 16);
   endtask

   initial begin
      repeat (3) step();
      reset_n = 1;
      chk_en = 1;
      @(negedge clock);
      chk("idle_in_ready", in_ready, 1);
      chk("idle_out_valid", out_valid, 0);
      step();
      issue(16'h4E71, 8'h43, 36'h43BC43BC5, 0, 0);
      issue(16'hA000, 8'hA0, 36'hA05FA05F5, 1, 0);
      issue(16'hF200, 8'hF0, 36'hF00FF00F5, 0, 1);
      out_ready = 0;
      in_valid = 1;
      in_opcode = 16'h3A28;
      @(negedge clock);
      chk("stall_first_addr", rom_addr, 8'h31);
      step();
      in_opcode = 16'h1234;
      repeat (5) begin
         @(negedge clock);
         chk("stall_word", out_word, 36'h31CE31CE5);
         chk("stall_opcode", out_opcode, 16'h3A28);
         chk("stall_rom_addr", rom_addr, 8'h31);
         chk("stall_in_ready", in_ready, 0);
         step();
      end
      in_valid = 0;
      out_ready = 1;
      step();
      in_valid = 1;
      in_opcode = 16'h5555;
      step();
      out_ready = 0;
      in_opcode = 16'h6666;
      flush = 1;
      @(negedge clock);
      chk("flush_in_ready", in_ready, 0);
      step();
      flush = 0;
      in_valid = 0;
      @(negedge clock);
      chk("flush_out_valid", out_valid, 0);
      out_ready = 1;
      step();
      in_valid = 1;
      in_opcode = 16'h7777;
      step();
      in_valid = 0;
      out_ready = 0;
      reset_n = 0;
      @(negedge clock);
      chk("rst_in_ready", in_ready, 0);
      step();
      @(negedge clock);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_op_cleared", out_opcode, 16'h0000);
      reset_n = 1;
      out_ready = 1;
      step();
      stream();
      step();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
